// File: rtl/multicycle_seq.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM with retire counter.
// Define ILLEGAL_TRAP_EN to halt in TRAP on undefined opcodes; otherwise they retire as NOPs.
module multicycle_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic       jump,
  output logic       instr_done,
  output logic [7:0] retired,
  output logic       trap,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } seqState;

  localparam logic [2:0] OpLw     = 3'b000;
  localparam logic [2:0] OpSw     = 3'b001;
  localparam logic [2:0] OpJmp    = 3'b010;
  localparam logic [2:0] OpRtype  = 3'b011;
  localparam logic [2:0] OpAddi   = 3'b100;
  localparam logic [2:0] OpRtype2 = 3'b101;

  seqState    curState;
  logic [2:0] opReg;
  logic [7:0] retiredCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      curState   <= StFetch;
      opReg      <= 3'b000;
      retiredCnt <= 8'd0;
    end else begin
      if (instr_done) begin
        retiredCnt <= retiredCnt + 8'd1;
      end
      case (curState)
        StFetch: begin
          if (mem_ready) begin
            curState <= StDecode;
          end
        end
        StDecode: begin
          opReg    <= opcode;
          curState <= StExec;
        end
        StExec: begin
          case (opReg)
            OpJmp:                     curState <= StFetch;
            OpLw, OpSw:                curState <= StMem;
            OpRtype, OpAddi, OpRtype2: curState <= StWb;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              curState <= StTrap;
`else
              curState <= StFetch;
`endif
            end
          endcase
        end
        StMem: begin
          if (mem_ready) begin
            curState <= (opReg == OpLw) ? StWb : StFetch;
          end
        end
        StWb:    curState <= StFetch;
        StTrap:  curState <= StTrap;
        default: curState <= StFetch;
      endcase
    end
  end

  // Strobes are forced low while rst is high so a reset mid-access never completes it.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    jump       = 1'b0;
    instr_done = 1'b0;
    if (!rst) begin
      case (curState)
        StFetch: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        StExec: begin
          alu_src = (opReg == OpLw) || (opReg == OpSw) || (opReg == OpAddi);
          case (opReg)
            OpJmp: begin
              pc_write   = 1'b1;
              jump       = 1'b1;
              instr_done = 1'b1;
            end
            OpLw, OpSw, OpRtype, OpAddi, OpRtype2: ;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              instr_done = 1'b0;
`else
              instr_done = 1'b1;
`endif
            end
          endcase
        end
        StMem: begin
          if (opReg == OpLw) begin
            mem_read = 1'b1;
            alu_src  = 1'b1;
          end else if (opReg == OpSw) begin
            mem_write  = 1'b1;
            alu_src    = 1'b1;
            instr_done = mem_ready;
          end
        end
        StWb: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          mem_to_reg = (opReg == OpLw);
          alu_src    = (opReg == OpAddi);
        end
        default: ;
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign trap = (curState == StTrap);
`else
  assign trap = 1'b0;
`endif

  assign retired = retiredCnt;
  assign state   = curState;

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq; strobe vector order is
// {pc_write, ir_write, mem_read, mem_write, reg_write, alu_src, mem_to_reg, jump, instr_done}.
module tb_multicycle_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       mem_ready;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write;
  logic       alu_src, mem_to_reg, jump, instr_done, trap;
  logic [7:0] retired;
  logic [2:0] state;
  logic [8:0] strobes;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_seq dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .jump       (jump),
    .instr_done (instr_done),
    .retired    (retired),
    .trap       (trap),
    .state      (state)
  );

  assign strobes = {pc_write, ir_write, mem_read, mem_write, reg_write,
                    alu_src, mem_to_reg, jump, instr_done};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let inputs settle, then check state and the whole strobe vector.
  task automatic cyc(input string tag, input logic [2:0] expState, input logic [8:0] expStrb);
    #1;
    chk({tag, ".state"}, 32'(state), 32'(expState));
    chk({tag, ".strb"}, 32'(strobes), 32'(expStrb));
  endtask

  initial begin
    rst = 1'b1;
    opcode = 3'b011;
    mem_ready = 1'b1;

    // Reset held two cycles with mem_ready high: all strobes low.
    tick();
    cyc("rst1", 3'd0, 9'b000_000_000);
    chk("rst1.retired", 32'(retired), 32'd0);
    chk("rst1.trap", 32'(trap), 32'd0);
    tick();
    cyc("rst2", 3'd0, 9'b000_000_000);
    rst = 1'b0;

    // RTYPE: 0,1,2,4,0
    cyc("rt.fetch", 3'd0, 9'b111_000_000); tick();
    cyc("rt.dec",   3'd1, 9'b000_000_000); tick();
    cyc("rt.exec",  3'd2, 9'b000_000_000); tick();
    cyc("rt.wb",    3'd4, 9'b000_010_001);
    chk("rt.wb.retired", 32'(retired), 32'd0);
    tick();
    cyc("rt.end", 3'd0, 9'b111_000_000);
    chk("rt.retired", 32'(retired), 32'd1);

    // LW with two wait cycles in MEM: 7 cycles total
    opcode = 3'b000;
    cyc("lw.fetch", 3'd0, 9'b111_000_000); tick();
    cyc("lw.dec",   3'd1, 9'b000_000_000); tick();
    cyc("lw.exec",  3'd2, 9'b000_001_000); tick();
    mem_ready = 1'b0;
    cyc("lw.mem0",  3'd3, 9'b001_001_000); tick();
    cyc("lw.mem1",  3'd3, 9'b001_001_000); tick();
    mem_ready = 1'b1;
    cyc("lw.mem2",  3'd3, 9'b001_001_000); tick();
    cyc("lw.wb",    3'd4, 9'b000_010_101); tick();
    cyc("lw.end",   3'd0, 9'b111_000_000);
    chk("lw.retired", 32'(retired), 32'd2);

    // SW zero-wait: 4 cycles, write and retire together in MEM
    opcode = 3'b001;
    cyc("sw.fetch", 3'd0, 9'b111_000_000); tick();
    cyc("sw.dec",   3'd1, 9'b000_000_000); tick();
    cyc("sw.exec",  3'd2, 9'b000_001_000); tick();
    cyc("sw.mem",   3'd3, 9'b000_101_001); tick();
    cyc("sw.end",   3'd0, 9'b111_000_000);
    chk("sw.retired", 32'(retired), 32'd3);

    // JMP: 3 cycles
    opcode = 3'b010;
    cyc("jmp.fetch", 3'd0, 9'b111_000_000); tick();
    cyc("jmp.dec",   3'd1, 9'b000_000_000); tick();
    cyc("jmp.exec",  3'd2, 9'b100_000_011); tick();
    cyc("jmp.end",   3'd0, 9'b111_000_000);
    chk("jmp.retired", 32'(retired), 32'd4);

    // ADDI: immediate operand in EXEC and WB
    opcode = 3'b100;
    cyc("addi.fetch", 3'd0, 9'b111_000_000); tick();
    cyc("addi.dec",   3'd1, 9'b000_000_000); tick();
    cyc("addi.exec",  3'd2, 9'b000_001_000); tick();
    cyc("addi.wb",    3'd4, 9'b000_011_001); tick();
    cyc("addi.end",   3'd0, 9'b111_000_000);
    chk("addi.retired", 32'(retired), 32'd5);

    // Reset during a stalled SW in MEM: write dropped, no retire
    opcode = 3'b001;
    cyc("swr.fetch", 3'd0, 9'b111_000_000); tick();
    cyc("swr.dec",   3'd1, 9'b000_000_000); tick();
    cyc("swr.exec",  3'd2, 9'b000_001_000); tick();
    mem_ready = 1'b0;
    cyc("swr.mem0",  3'd3, 9'b000_101_000); tick();
    cyc("swr.mem1",  3'd3, 9'b000_101_000);
    rst = 1'b1;
    cyc("swr.rstin", 3'd3, 9'b000_000_000);
    tick();
    cyc("swr.rst",   3'd0, 9'b000_000_000);
    rst = 1'b0;
    cyc("swr.after", 3'd0, 9'b001_000_000);
    chk("swr.retired", 32'(retired), 32'd0);
    mem_ready = 1'b1;

    // Undefined opcode 110
    opcode = 3'b110;
    cyc("ill.fetch", 3'd0, 9'b111_000_000); tick();
    cyc("ill.dec",   3'd1, 9'b000_000_000); tick();
`ifdef ILLEGAL_TRAP_EN
    cyc("ill.exec",  3'd2, 9'b000_000_000); tick();
    cyc("ill.trap0", 3'd5, 9'b000_000_000);
    chk("ill.trap0.trap", 32'(trap), 32'd1);
    tick();
    cyc("ill.trap1", 3'd5, 9'b000_000_000);
    chk("ill.trap1.trap", 32'(trap), 32'd1);
    chk("ill.retired", 32'(retired), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cyc("ill.rst", 3'd0, 9'b111_000_000);
    chk("ill.rst.trap", 32'(trap), 32'd0);
`else
    cyc("ill.exec",  3'd2, 9'b000_000_001); tick();
    cyc("ill.end",   3'd0, 9'b111_000_000);
    chk("ill.trap", 32'(trap), 32'd0);
    chk("ill.retired", 32'(retired), 32'd1);
`endif

    // Retire counter wrap: 255 RTYPEs, then one more
    rst = 1'b1;
    tick();
    rst = 1'b0;
    opcode = 3'b011;
    mem_ready = 1'b1;
    #1;
    chk("wrap.start", 32'(retired), 32'd0);
    repeat (255 * 4) tick();
    cyc("wrap.255", 3'd0, 9'b111_000_000);
    chk("wrap.255.retired", 32'(retired), 32'd255);
    repeat (4) tick();
    cyc("wrap.0", 3'd0, 9'b111_000_000);
    chk("wrap.0.retired", 32'(retired), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
